// File: rtl/sram_responder.sv
// sram_responder: single-outstanding SRAM-style responder with a fixed
// accept-to-completion latency and a byte-strobed word memory.
module sram_responder #(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req,
    input  logic        wr,
    input  logic [3:0]  wstrb,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata,
    output logic        err
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = 4;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned DEPTH  = 1 << ADDR_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                wr_q, wr_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic                bad_q, bad_d;
    logic                data_ok_q, data_ok_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;
    logic                enter_resp;
    logic                mem_we;

    logic [DATA_W-1:0]   mem [DEPTH];

    assign addr_ok = (state_q == IDLE);
    assign data_ok = data_ok_q;
    assign rdata   = rdata_q;
    assign err     = err_q;

    // Next-state, request latch and completion-edge response computation.
    // The *_d request fields are the ones in force at the RESP-entry edge,
    // which covers both the direct IDLE->RESP path and the WAIT->RESP path.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wr_d       = wr_q;
        wstrb_d    = wstrb_q;
        wdata_d    = wdata_q;
        idx_d      = idx_q;
        bad_d      = bad_q;
        data_ok_d  = 1'b0;
        rdata_d    = rdata_q;
        err_d      = err_q;
        enter_resp = 1'b0;
        mem_we     = 1'b0;

        case (state_q)
            IDLE: begin
                if (req) begin
                    wr_d    = wr;
                    wstrb_d = wstrb;
                    wdata_d = wdata;
                    idx_d   = addr[ADDR_W+1:2];
                    bad_d   = (addr[1:0] != 2'b00) ||
                              ((addr >> (ADDR_W + 2)) != 32'd0);
                    if (LATENCY == 1) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = (LATENCY >= 2) ? CNT_W'(LATENCY - 2) : '0;
                    end
                end
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (enter_resp) begin
            data_ok_d = 1'b1;
            err_d     = bad_d;
            mem_we    = wr_d && !bad_d;
            if (!wr_d) begin
                rdata_d = bad_d ? '0 : mem[idx_d];
            end
        end
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            wr_q      <= 1'b0;
            wstrb_q   <= '0;
            wdata_q   <= '0;
            idx_q     <= '0;
            bad_q     <= 1'b0;
            data_ok_q <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_q      <= wr_d;
            wstrb_q   <= wstrb_d;
            wdata_q   <= wdata_d;
            idx_q     <= idx_d;
            bad_q     <= bad_d;
            data_ok_q <= data_ok_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end

    // Memory array: contents are deliberately not reset; byte-strobed write.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < int'(STRB_W); i++) begin
                if (wstrb_d[i]) begin
                    mem[idx_d][8*i +: 8] <= wdata_d[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_sram_responder.sv
// Scoreboard bench for sram_responder: three instances (LATENCY 2, 1, 4).
module tb_sram_responder;

    localparam int unsigned NU = 3;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic                  clk;
    logic [NU-1:0]         resetn;
    logic [NU-1:0]         req;
    logic [NU-1:0]         wr;
    logic [NU-1:0][3:0]    wstrb;
    logic [NU-1:0][31:0]   addr;
    logic [NU-1:0][31:0]   wdata;
    logic [NU-1:0]         addr_ok;
    logic [NU-1:0]         data_ok;
    logic [NU-1:0][31:0]   rdata;
    logic [NU-1:0]         err;

    exp_t        exp_q [NU][$];
    int          due_q [NU][$];
    int          win_end [NU];
    int          last_acc [NU];
    bit          have_acc [NU];
    bit          held [NU];
    logic [31:0] last_rd [NU];
    int          checks;
    int          errors;
    int          neg_n;

    genvar g;
    generate
        for (g = 0; g < int'(NU); g++) begin : g_dut
            sram_responder #(
                .ADDR_W (10),
                .LATENCY((g == 0) ? 2 : ((g == 1) ? 1 : 4))
            ) u_dut (
                .clk    (clk),
                .resetn (resetn[g]),
                .req    (req[g]),
                .wr     (wr[g]),
                .wstrb  (wstrb[g]),
                .addr   (addr[g]),
                .wdata  (wdata[g]),
                .addr_ok(addr_ok[g]),
                .data_ok(data_ok[g]),
                .rdata  (rdata[g]),
                .err    (err[g])
            );
        end
    endgenerate

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int lat_of(input int u);
        return (u == 0) ? 2 : ((u == 1) ? 1 : 4);
    endfunction

    task automatic chk(input string nm, input int u, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s u%0d: got %h want %h (neg %0d)", nm, u, act, exp, neg_n);
        end
    endtask

    // Monitor: reset values, addr_ok busy windows, accept spacing, and
    // in-order completion timing/data against the scoreboard queues.
    always @(negedge clk) begin
        neg_n++;
        for (int u = 0; u < int'(NU); u++) begin
            if (!resetn[u]) begin
                exp_q[u].delete();
                due_q[u].delete();
                win_end[u]  = 0;
                have_acc[u] = 0;
                held[u]     = 0;
                chk("rst_addr_ok", u, 32'(addr_ok[u]), 32'd1);
                chk("rst_data_ok", u, 32'(data_ok[u]), 32'd0);
                chk("rst_rdata",   u, rdata[u],        32'd0);
                chk("rst_err",     u, 32'(err[u]),     32'd0);
            end else begin
                if (neg_n <= win_end[u])
                    chk("busy_addr_ok", u, 32'(addr_ok[u]), 32'd0);
                else if (win_end[u] != 0 && neg_n == win_end[u] + 1)
                    chk("idle_addr_ok", u, 32'(addr_ok[u]), 32'd1);

                if (data_ok[u]) begin
                    if (exp_q[u].size() == 0 || due_q[u].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_data_ok u%0d: got data_ok=1 want no response (neg %0d)", u, neg_n);
                    end else begin
                        exp_t e;
                        int   d;
                        e = exp_q[u].pop_front();
                        d = due_q[u].pop_front();
                        chk("resp_cycle", u, 32'(neg_n), 32'(d));
                        chk("resp_rdata", u, rdata[u], e.rdata);
                        chk("resp_err",   u, 32'(err[u]), 32'(e.err));
                    end
                end else if (due_q[u].size() != 0 && due_q[u][0] <= neg_n) begin
                    checks++;
                    errors++;
                    $display("FAIL missing_data_ok u%0d: got data_ok=0 want 1 (neg %0d)", u, neg_n);
                    void'(due_q[u].pop_front());
                    if (exp_q[u].size() != 0) void'(exp_q[u].pop_front());
                end

                if (req[u] && addr_ok[u]) begin
                    if (have_acc[u] && held[u])
                        chk("accept_gap", u, 32'(neg_n - last_acc[u]), 32'(lat_of(u) + 1));
                    last_acc[u] = neg_n;
                    have_acc[u] = 1;
                    held[u]     = 1;
                    due_q[u].push_back(neg_n + lat_of(u));
                    win_end[u]  = neg_n + lat_of(u);
                end
                if (!req[u]) held[u] = 0;
            end
        end
    end

    // Present one request, push its expected response, wait for acceptance.
    // Returns just after the accept edge with req still high.
    task automatic issue(input int u, input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic [31:0] exp_rd, input logic exp_err);
        exp_t e;
        int   n;
        e.rdata = exp_rd;
        e.err   = exp_err;
        exp_q[u].push_back(e);
        req[u]   = 1'b1;
        wr[u]    = w;
        addr[u]  = a;
        wdata[u] = d;
        wstrb[u] = s;
        n = 0;
        forever begin
            @(negedge clk);
            if (addr_ok[u]) break;
            n++;
            if (n > 50) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout u%0d: got addr_ok=0 want 1 within 50 cycles", u);
                req[u] = 1'b0;
                return;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_wr(input int u, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic exp_err);
        issue(u, 1'b1, a, d, s, last_rd[u], exp_err);
    endtask

    task automatic do_rd(input int u, input logic [31:0] a, input logic [31:0] exp_rd, input logic exp_err);
        issue(u, 1'b0, a, 32'd0, 4'd0, exp_rd, exp_err);
        last_rd[u] = exp_rd;
    endtask

    task automatic finish_txn(input int u);
        int n;
        req[u] = 1'b0;
        n = 0;
        while (exp_q[u].size() != 0 && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (exp_q[u].size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout u%0d: got %0d pending want 0", u, exp_q[u].size());
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        neg_n  = 0;
        req    = '0;
        wr     = '0;
        wstrb  = '0;
        addr   = '0;
        wdata  = '0;
        resetn = '1;
        for (int u = 0; u < int'(NU); u++) begin
            last_rd[u]  = 32'd0;
            win_end[u]  = 0;
            last_acc[u] = 0;
            have_acc[u] = 0;
            held[u]     = 0;
        end
        #1 resetn = '0;
        repeat (3) @(posedge clk);
        #1 resetn = '1;

        // LATENCY = 2: write/read, byte strobes, bad addresses
        do_wr(0, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0); finish_txn(0);
        do_rd(0, 32'h10, 32'hDEADBEEF, 1'b0);       finish_txn(0);
        do_wr(0, 32'h20, 32'h11223344, 4'hF, 1'b0); finish_txn(0);
        do_wr(0, 32'h20, 32'hAABBCCDD, 4'b0101, 1'b0); finish_txn(0);
        do_rd(0, 32'h20, 32'h11BB33DD, 1'b0);       finish_txn(0);
        do_wr(0, 32'h20, 32'hFFFFFFFF, 4'h0, 1'b0); finish_txn(0);
        do_rd(0, 32'h20, 32'h11BB33DD, 1'b0);       finish_txn(0);
        do_rd(0, 32'h12, 32'h00000000, 1'b1);       finish_txn(0);
        do_wr(0, 32'h0,  32'hCAFEF00D, 4'hF, 1'b0); finish_txn(0);
        do_wr(0, 32'h1000, 32'h12345678, 4'hF, 1'b1); finish_txn(0);
        do_rd(0, 32'h0,  32'hCAFEF00D, 1'b0);       finish_txn(0);
        do_rd(0, 32'h1000, 32'h00000000, 1'b1);     finish_txn(0);

        // LATENCY = 1: req held high across four requests
        do_wr(1, 32'h0, 32'hA1A1A1A1, 4'hF, 1'b0);
        do_wr(1, 32'h4, 32'hB2B2B2B2, 4'hF, 1'b0);
        do_rd(1, 32'h0, 32'hA1A1A1A1, 1'b0);
        do_rd(1, 32'h4, 32'hB2B2B2B2, 1'b0);
        finish_txn(1);

        // LATENCY = 4: reset while the write is still in WAIT
        do_wr(2, 32'h30, 32'h00000000, 4'hF, 1'b0); finish_txn(2);
        do_wr(2, 32'h30, 32'h55555555, 4'hF, 1'b0);
        req[2] = 1'b0;
        @(posedge clk);
        #1;
        resetn[2]  = 1'b0;
        last_rd[2] = 32'd0;
        repeat (2) @(posedge clk);
        #1 resetn[2] = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        do_rd(2, 32'h30, 32'h00000000, 1'b0);       finish_txn(2);

        repeat (5) @(posedge clk);
        #1;
        for (int u = 0; u < int'(NU); u++)
            chk("leftover", u, 32'(exp_q[u].size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
